// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: merges ALU and LSU results onto the single
// write port, registers the winner for one cycle and exposes it as a bypass.
module wb_arbiter #(
   parameter int ADDR_WDTH  = 5,
   parameter int DATA_WDTH  = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 alu_valid_i,
   output logic                 alu_ready_o,
   input  logic [ADDR_WDTH-1:0] alu_rd_i,
   input  logic [DATA_WDTH-1:0] alu_wd_i,
   input  logic                 lsu_valid_i,
   output logic                 lsu_ready_o,
   input  logic [ADDR_WDTH-1:0] lsu_rd_i,
   input  logic [DATA_WDTH-1:0] lsu_wd_i,
   output logic                 we3_o,
   output logic [ADDR_WDTH-1:0] ad3_o,
   output logic [DATA_WDTH-1:0] wd3_o,
   input  logic [ADDR_WDTH-1:0] rs1_i,
   input  logic [ADDR_WDTH-1:0] rs2_i,
   output logic                 rs1_hit_o,
   output logic                 rs2_hit_o,
   output logic [DATA_WDTH-1:0] byp_wd_o
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef struct packed {
      logic [ADDR_WDTH-1:0] rd;
      logic [DATA_WDTH-1:0] wd;
   } wb_req_t;

   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_nxt;
   logic             starve_full;
   logic             force_lsu;
   logic             alu_xfer;
   logic             lsu_xfer;
   logic             win_xfer;
   logic             win_wr;
   wb_req_t          win_req;

   assign starve_full = (starve_cnt == STARVE_LIM);
   assign force_lsu   = lsu_valid_i & starve_full;

   // Readies never look at their own source's valid, so producers may wait on ready.
   assign alu_ready_o = rst_ni & ~force_lsu;
   assign lsu_ready_o = rst_ni & (~alu_valid_i | starve_full);

   // The ready terms are mutually exclusive whenever both sources are valid.
   assign alu_xfer = alu_valid_i & alu_ready_o;
   assign lsu_xfer = lsu_valid_i & lsu_ready_o;
   assign win_xfer = alu_xfer | lsu_xfer;

   always_comb begin
      win_req = '{rd: alu_rd_i, wd: alu_wd_i};
      if (lsu_xfer) begin
         win_req = '{rd: lsu_rd_i, wd: lsu_wd_i};
      end
   end

   // x0 writes are consumed at the handshake but never reach the port.
   assign win_wr = win_xfer & (win_req.rd != '0);

   always_comb begin
      starve_nxt = starve_cnt;
      if (!lsu_valid_i || lsu_xfer) begin
         starve_nxt = '0;
      end else if (!starve_full) begin
         starve_nxt = starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         we3_o      <= 1'b0;
         ad3_o      <= '0;
         wd3_o      <= '0;
         starve_cnt <= '0;
      end else begin
         we3_o      <= win_wr;
         starve_cnt <= starve_nxt;
         if (win_wr) begin
            ad3_o <= win_req.rd;
            wd3_o <= win_req.wd;
         end
      end
   end

   assign rs1_hit_o = we3_o & (ad3_o == rs1_i) & (rs1_i != '0);
   assign rs2_hit_o = we3_o & (ad3_o == rs2_i) & (rs2_i != '0);
   assign byp_wd_o  = wd3_o;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios plus randomized traffic
// checked against a grant-rule model of the arbiter.
module tb_wb_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int SM = 3;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          alu_valid_i = 1'b0, lsu_valid_i = 1'b0;
   logic [AW-1:0] alu_rd_i = '0, lsu_rd_i = '0, rs1_i = '0, rs2_i = '0;
   logic [DW-1:0] alu_wd_i = '0, lsu_wd_i = '0;
   logic          alu_ready_o, lsu_ready_o, we3_o, rs1_hit_o, rs2_hit_o;
   logic [AW-1:0] ad3_o;
   logic [DW-1:0] wd3_o, byp_wd_o;

   wb_arbiter #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .STARVE_MAX(SM)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
      .alu_rd_i(alu_rd_i), .alu_wd_i(alu_wd_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
      .lsu_rd_i(lsu_rd_i), .lsu_wd_i(lsu_wd_i),
      .we3_o(we3_o), .ad3_o(ad3_o), .wd3_o(wd3_o),
      .rs1_i(rs1_i), .rs2_i(rs2_i),
      .rs1_hit_o(rs1_hit_o), .rs2_hit_o(rs2_hit_o), .byp_wd_o(byp_wd_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            stamp;
      logic [AW-1:0] rd;
      logic [DW-1:0] wd;
   } exp_t;

   exp_t          sb_q[$];
   int            ntests = 0;
   int            nfail = 0;
   int            cyc = 0;
   logic          rst_seen = 1'b0;
   int            lost = 0;        // consecutive cycles the LSU has waited
   logic [AW-1:0] m_ad = '0;
   logic [DW-1:0] m_wd = '0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst_ni;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock of stimulus; the model decides the winner of the coming edge.
   task automatic cycle(input logic rst, input logic av, input logic [AW-1:0] ar,
                        input logic [DW-1:0] aw, input logic lv, input logic [AW-1:0] lr,
                        input logic [DW-1:0] lw, input logic [AW-1:0] r1,
                        input logic [AW-1:0] r2, output logic a_acc, output logic l_acc);
      logic starved;
      @(posedge clk);
      #1;
      rst_ni = rst; alu_valid_i = av; alu_rd_i = ar; alu_wd_i = aw;
      lsu_valid_i = lv; lsu_rd_i = lr; lsu_wd_i = lw; rs1_i = r1; rs2_i = r2;
      #2;
      starved = (lost >= SM);
      chk("alu_ready", alu_ready_o, rst && !(lv && starved));
      chk("lsu_ready", lsu_ready_o, rst && (!av || starved));
      a_acc = 1'b0;
      l_acc = 1'b0;
      if (rst) begin
         if (lv && starved) l_acc = 1'b1;
         else if (av)       a_acc = 1'b1;
         else if (lv)       l_acc = 1'b1;
      end
      if (a_acc && ar != 0) sb_q.push_back('{stamp: cyc, rd: ar, wd: aw});
      if (l_acc && lr != 0) sb_q.push_back('{stamp: cyc, rd: lr, wd: lw});
      if (!rst || !lv || l_acc) lost = 0;
      else if (lost < SM)       lost++;
   endtask

   task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      logic a, l;
      cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, r1, r2, a, l);
   endtask

   // Monitor: every cycle the write stage either shows the queued write or nothing.
   always @(negedge clk) begin
      logic exp_we;
      exp_t e;
      exp_we = 1'b0;
      while (sb_q.size() > 0 && sb_q[0].stamp < cyc - 1) begin
         e = sb_q.pop_front();
         chk("missed_write", 64'(e.rd), 64'hFFFF);
      end
      if (sb_q.size() > 0 && sb_q[0].stamp == cyc - 1) begin
         e = sb_q.pop_front();
         exp_we = 1'b1;
         m_ad = e.rd;
         m_wd = e.wd;
      end else if (!rst_seen) begin
         m_ad = '0;
         m_wd = '0;
      end
      chk("we3", we3_o, exp_we);
      chk("ad3", ad3_o, m_ad);
      chk("wd3", wd3_o, m_wd);
      chk("byp_wd", byp_wd_o, m_wd);
      chk("rs1_hit", rs1_hit_o, exp_we && m_ad == rs1_i && rs1_i != 0);
      chk("rs2_hit", rs2_hit_o, exp_we && m_ad == rs2_i && rs2_i != 0);
   end

   initial begin
      logic a, l;
      logic          apend, lpend;
      logic [AW-1:0] ard, lrd;
      logic [DW-1:0] awd, lwd;
      logic          rst;

      // Reset held for two cycles with both sources requesting.
      cycle(1'b0, 1'b1, 5'd4, 32'h1, 1'b1, 5'd6, 32'h2, '0, '0, a, l);
      cycle(1'b0, 1'b1, 5'd4, 32'h1, 1'b1, 5'd6, 32'h2, '0, '0, a, l);
      chk("rst_alu_ready", alu_ready_o, 0);
      chk("rst_lsu_ready", lsu_ready_o, 0);
      chk("rst_we3", we3_o, 0);
      chk("rst_ad3", ad3_o, 0);
      chk("rst_wd3", wd3_o, 0);
      chk("rst_starve_cnt", 64'(dut.starve_cnt), 0);

      // Single ALU write.
      cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, '0, '0, a, l);
      chk("alu_single_ready", alu_ready_o, 1);
      idle('0, '0);
      chk("alu_single_we3", we3_o, 1);
      chk("alu_single_ad3", ad3_o, 5);
      chk("alu_single_wd3", wd3_o, 32'hDEADBEEF);
      idle('0, '0);
      chk("alu_single_we3_drop", we3_o, 0);

      // Contention: grants A,A,A,L repeating.
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b1, 5'd1, 32'h1111_0000 + 32'(i), 1'b1, 5'd2,
               (i < 4) ? 32'h2222_0000 : 32'h2222_0001, '0, '0, a, l);
         chk("contend_lsu_ready", lsu_ready_o, (i % 4) == 3);
         chk("contend_lsu_grant", l, (i % 4) == 3);
      end
      idle('0, '0);
      chk("contend_last_ad3", ad3_o, 2);

      // x0 write is consumed but dropped.
      cycle(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, '0, '0, a, l);
      chk("x0_lsu_ready", lsu_ready_o, 1);
      idle('0, '0);
      chk("x0_we3", we3_o, 0);
      chk("x0_rs1_hit", rs1_hit_o, 0);

      // Bypass.
      cycle(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, '0, '0, '0, '0, a, l);
      idle(5'd7, 5'd8);
      chk("byp_rs1_hit", rs1_hit_o, 1);
      chk("byp_rs2_hit", rs2_hit_o, 0);
      chk("byp_data", byp_wd_o, 32'hA5A5A5A5);

      // Reset mid-stream after an LSU has started waiting.
      cycle(1'b1, 1'b1, 5'd3, 32'h3333, 1'b1, 5'd9, 32'h9999, '0, '0, a, l);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, a, l);
      idle(5'd3, '0);
      chk("midrst_we3", we3_o, 0);
      chk("midrst_rs1_hit", rs1_hit_o, 0);
      chk("midrst_starve_cnt", 64'(dut.starve_cnt), 0);

      // Randomized traffic; producers hold their request until accepted.
      apend = 1'b0; lpend = 1'b0;
      ard = '0; lrd = '0; awd = '0; lwd = '0;
      for (int i = 0; i < 600; i++) begin
         if (!apend && ($urandom_range(0, 3) != 0)) begin
            apend = 1'b1; ard = AW'($urandom_range(0, 7)); awd = $urandom;
         end
         if (!lpend && ($urandom_range(0, 2) != 0)) begin
            lpend = 1'b1; lrd = AW'($urandom_range(0, 7)); lwd = $urandom;
         end
         rst = ($urandom_range(0, 79) != 0);
         cycle(rst, apend, ard, awd, lpend, lrd, lwd,
               AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), a, l);
         if (a) apend = 1'b0;
         if (l) lpend = 1'b0;
         if (!rst) begin
            apend = 1'b0;
            lpend = 1'b0;
         end
      end

      idle('0, '0);
      idle('0, '0);
      @(negedge clk);
      #1;
      chk("scoreboard_drain", 64'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Sole driver of the register-file write port (ad3/we3/wd3).
- Merges write-back requests from two producers, the single-cycle ALU path and the multi-cycle load/store unit (LSU), onto that one port using valid/ready handshakes.
- ALU has fixed priority. A starvation counter bounds how long the LSU can wait.
- Registers the winning write for one cycle and exposes it as a bypass. Readers in the decode stage see a write that is in flight in the same cycle the register file commits it.

Parameters:
- ADDR_WDTH, 5, register index width.
- DATA_WDTH, 32, register data width.
- STARVE_MAX, 3, consecutive lost cycles after which the LSU is forced to win. Legal range is at least 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  synchronous active-low reset.
- alu_valid_i  input  1  ALU write-back request.
- alu_ready_o  output  1  ALU request accepted this cycle.
- alu_rd_i  input  ADDR_WDTH  ALU destination register.
- alu_wd_i  input  DATA_WDTH  ALU result.
- lsu_valid_i  input  1  LSU write-back request.
- lsu_ready_o  output  1  LSU request accepted this cycle.
- lsu_rd_i  input  ADDR_WDTH  LSU destination register.
- lsu_wd_i  input  DATA_WDTH  LSU load data.
- we3_o  output  1  register-file write enable.
- ad3_o  output  ADDR_WDTH  register-file write address.
- wd3_o  output  DATA_WDTH  register-file write data.
- rs1_i  input  ADDR_WDTH  decode-stage read index 1.
- rs2_i  input  ADDR_WDTH  decode-stage read index 2.
- rs1_hit_o  output  1  in-flight write targets rs1_i.
- rs2_hit_o  output  1  in-flight write targets rs2_i.
- byp_wd_o  output  DATA_WDTH  bypass data; equals wd3_o.

Behaviour:
- Reset, while rst_ni=0 at a clock edge:
  - we3_o=0, ad3_o=0, wd3_o=0, starve_cnt=0.
  - alu_ready_o=0 and lsu_ready_o=0 combinationally while rst_ni=0.
- Force condition: force_lsu = lsu_valid_i AND starve_cnt==STARVE_MAX.
- Ready signals, combinational, with rst_ni=1:
  - alu_ready_o = NOT force_lsu.
  - lsu_ready_o = (NOT alu_valid_i) OR (starve_cnt==STARVE_MAX).
  - The readies do not depend on their own source's valid.
- Handshake: a source transfers when valid AND ready are both high at a rising edge. At most one transfer per cycle. Producers must hold rd/wd stable while valid is high and ready is low.
- Write stage, registered:
  - On a transfer with rd!=0: we3_o<=1, ad3_o<=rd, wd3_o<=wd at that edge.
  - Otherwise: we3_o<=0, with ad3_o/wd3_o holding their values.
  - Latency is exactly 1 cycle from handshake to we3_o high. The register file commits on the following edge.
- Writes to x0: the handshake completes (ready asserted, request consumed), but we3_o stays 0 and no bypass hit is raised.
- Starvation counter, saturating at STARVE_MAX:
  - Reset to 0 when lsu_valid_i=0 or the LSU transfers.
  - Incremented when lsu_valid_i=1 and the LSU does not transfer.
  - With both sources continuously valid, the grant pattern is A,A,…,A (STARVE_MAX times),L, repeating.
- Bypass, combinational:
  - rsN_hit_o = we3_o AND (ad3_o==rsN_i) AND (rsN_i!=0).
  - byp_wd_o = wd3_o at all times. Decode muxes byp_wd_o over the register-file read data when a hit is raised.
- Reset mid-operation: any pending write in the stage is discarded (we3_o=0 next cycle) and starve_cnt is cleared. Producers must re-present their requests after reset.
- No internal buffering beyond the single write stage. The register file never stalls, so the stage drains every cycle.

Test Plan:
- Reset: rst_ni=0 for 2 cycles with both valids high -> both readies 0; we3_o=0, ad3_o=0, wd3_o=0 after the edge; starve_cnt=0.
- Single ALU write: alu_valid_i=1, alu_rd_i=5, alu_wd_i=0xDEADBEEF for one cycle -> alu_ready_o=1; next cycle we3_o=1, ad3_o=5, wd3_o=0xDEADBEEF; the cycle after, we3_o=0.
- Contention (STARVE_MAX=3): both valid for 8 cycles, ALU rd=1, LSU rd=2 -> we3_o addresses 1,1,1,2,1,1,1,2 on consecutive cycles, each one cycle after its grant; lsu_ready_o high only on grant cycles 3 and 7.
- x0 drop: lsu_valid_i=1, lsu_rd_i=0, lsu_wd_i=0x1234, alu idle -> lsu_ready_o=1; next cycle we3_o=0 and rs1_hit_o=0 with rs1_i=0.
- Bypass: ALU writes rd=7 with 0xA5A5A5A5; in the write cycle set rs1_i=7, rs2_i=8 -> rs1_hit_o=1, byp_wd_o=0xA5A5A5A5, rs2_hit_o=0.
- Reset mid-stream: during an ALU transfer to rd=3, assert rst_ni=0 at the next edge -> we3_o=0 the cycle after reset; no write to x3; starve_cnt=0.
